mem_port_arbiter: RTL

Shares the single-port 32x8 program/data memory between the CPU datapath (fetch/operand/STO accesses) and a host debug/loader port. Decides one access per cycle, steers address, data and strobes to the memory, and returns read data to the winner. It also supports a host lock, which halts CPU memory access for program load or inspection. It sits between the CPU address mux/accumulator path and the memory instance.

---
 rtl/mem_port_arbiter_pkg.sv | 21 ++
 rtl/mem_port_arbiter_starve.sv | 29 ++
 rtl/mem_port_arbiter.sv | 133 +++++++++++++
 3 files changed

// File: rtl/mem_port_arbiter_pkg.sv
// rtl/mem_port_arbiter_pkg.sv - memory geometry constants and arbiter types
package mem_port_arbiter_pkg;

    localparam int MEM_ADDR_W       = 5;
    localparam int MEM_DATA_W       = 8;
    localparam int DEF_STARVE_LIMIT = 3;
    localparam int STARVE_CNT_W     = 4;

    typedef enum logic [1:0] {
        SHARED,
        LOCK_PEND,
        LOCKED
    } arb_state_t;

    typedef enum logic [1:0] {
        OWN_NONE,
        OWN_CPU,
        OWN_HOST
    } owner_t;

endpackage

// File: rtl/mem_port_arbiter_starve.sv
// rtl/mem_port_arbiter_starve.sv - saturating count of contended cycles lost by the host
module arb_starve_counter
    import mem_port_arbiter_pkg::*;
#(
    parameter int LIMIT = DEF_STARVE_LIMIT,
    parameter int CNT_W = STARVE_CNT_W
) (
    input  logic clk,
    input  logic rst,
    input  logic inc,
    input  logic clr,
    output logic limit_hit
);

    logic [CNT_W-1:0] cnt;

    assign limit_hit = (cnt == CNT_W'(LIMIT));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && !limit_hit) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - shares the single-port program/data memory between CPU and host
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W       = MEM_ADDR_W,
    parameter int DATA_W       = MEM_DATA_W,
    parameter int STARVE_LIMIT = DEF_STARVE_LIMIT
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cpu_req,
    input  logic              cpu_we,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [DATA_W-1:0] cpu_wdata,
    output logic              cpu_gnt,
    output logic              cpu_rvalid,
    output logic [DATA_W-1:0] cpu_rdata,
    output logic              cpu_stall,
    input  logic              host_req,
    input  logic              host_we,
    input  logic [ADDR_W-1:0] host_addr,
    input  logic [DATA_W-1:0] host_wdata,
    output logic              host_gnt,
    output logic              host_rvalid,
    output logic [DATA_W-1:0] host_rdata,
    input  logic              host_lock_req,
    output logic              host_lock_ack,
    output logic              mem_rd,
    output logic              mem_wr,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);

    arb_state_t        state, state_nxt;
    owner_t            rd_tag;
    logic              lock_req_q;
    logic              lock_rise;
    logic              cpu_win, host_win;
    logic              starve_inc;
    logic              limit_hit;
    logic [DATA_W-1:0] cpu_rdata_q, host_rdata_q;

    assign lock_rise = host_lock_req & ~lock_req_q;

    always_comb begin
        state_nxt  = state;
        cpu_win    = 1'b0;
        host_win   = 1'b0;
        starve_inc = 1'b0;
        case (state)
            SHARED: begin
                if (cpu_req && host_req) begin
                    if (limit_hit) begin
                        host_win = 1'b1;
                    end else begin
                        cpu_win    = 1'b1;
                        starve_inc = 1'b1;
                    end
                end else begin
                    cpu_win  = cpu_req;
                    host_win = host_req;
                end
                if (lock_rise) state_nxt = LOCK_PEND;
            end
            // CPU is fenced off here; one cycle lets an in-flight CPU read return
            LOCK_PEND: begin
                host_win  = host_req;
                state_nxt = host_lock_req ? LOCKED : SHARED;
            end
            LOCKED: begin
                host_win = host_req;
                if (!host_lock_req) state_nxt = SHARED;
            end
            default: state_nxt = SHARED;
        endcase
    end

    // Grants are combinational, so gate them while reset is held to keep outputs quiet
    assign cpu_gnt   = cpu_win & ~rst;
    assign host_gnt  = host_win & ~rst;
    assign cpu_stall = ~rst & ((cpu_req & ~cpu_gnt) | (state != SHARED));

    assign mem_rd = (cpu_gnt & ~cpu_we) | (host_gnt & ~host_we);
    assign mem_wr = (cpu_gnt & cpu_we) | (host_gnt & host_we);

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        if (cpu_gnt) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
        end else if (host_gnt) begin
            mem_addr  = host_addr;
            mem_wdata = host_wdata;
        end
    end

    arb_starve_counter #(
        .LIMIT (STARVE_LIMIT),
        .CNT_W (STARVE_CNT_W)
    ) u_starve (
        .clk       (clk),
        .rst       (rst),
        .inc       (starve_inc),
        .clr       (host_gnt),
        .limit_hit (limit_hit)
    );

    assign cpu_rvalid  = (rd_tag == OWN_CPU);
    assign host_rvalid = (rd_tag == OWN_HOST);
    assign cpu_rdata   = cpu_rvalid  ? mem_rdata : cpu_rdata_q;
    assign host_rdata  = host_rvalid ? mem_rdata : host_rdata_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state         <= SHARED;
            lock_req_q    <= 1'b0;
            rd_tag        <= OWN_NONE;
            host_lock_ack <= 1'b0;
            cpu_rdata_q   <= '0;
            host_rdata_q  <= '0;
        end else begin
            state         <= state_nxt;
            lock_req_q    <= host_lock_req;
            host_lock_ack <= (state_nxt == LOCKED);
            rd_tag        <= mem_rd ? (cpu_gnt ? OWN_CPU : OWN_HOST) : OWN_NONE;
            if (cpu_rvalid)  cpu_rdata_q  <= mem_rdata;
            if (host_rvalid) host_rdata_q <= mem_rdata;
        end
    end

endmodule
